hd_program_loader: RTL and testbench
====================================

HD_PROGRAM_LOADER -- requirements
Module: hd_program_loader

Interface
REQ-001 Parameter MEM_PROF, default 201: maximum words per transfer (instruction memory depth).
REQ-002 clock  in  1  single clock; all state changes on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 iniciarLeitura  in  1  start pulse; sampled only in IDLE.
REQ-005 enderecoHD  in  32  first HD word address of the program; captured at start.
REQ-006 tamanhoPrograma  in  32  program length in words; captured at start.
REQ-007 hdEndereco  out  32  HD read address.
REQ-008 hdLeitura  out  1  HD read strobe.
REQ-009 hdDado  in  32  HD read data, valid the cycle after hdLeitura=1.
REQ-010 saidaDeInstrucao  out  32  instruction word to the instruction memory.
REQ-011 controleSalvaInstrucao  out  2  2'b01 = store saidaDeInstrucao, advance cursor; else 2'b00.
REQ-012 ControleFimDeLeitura  out  2  2'b01 = transfer finished; else 2'b00.
REQ-013 ocupado  out  1  high in every state except IDLE.
REQ-014 palavrasEnviadas  out  32  words delivered in current or last transfer.
REQ-015 erroTamanho  out  1  set when tamanhoPrograma > MEM_PROF; cleared at next start.

Function
REQ-016 FSM states: IDLE, LER, ESPERA, ENVIA, FIM; all outputs registered.
REQ-017 IDLE: on iniciarLeitura=1, capture address, length N = min(tamanhoPrograma, MEM_PROF), clear palavrasEnviadas, go LER; if N=0 go FIM directly.
REQ-018 LER (1 cycle): hdLeitura=1, hdEndereco = base + palavrasEnviadas; go ESPERA.
REQ-019 ESPERA (1 cycle): hdLeitura=0; register hdDado into saidaDeInstrucao; go ENVIA.
REQ-020 ENVIA (1 cycle): controleSalvaInstrucao=2'b01, saidaDeInstrucao held stable the whole cycle, ControleFimDeLeitura=2'b00; palavrasEnviadas increments by 1; go LER if count < N else FIM.
REQ-021 FIM (1 cycle): ControleFimDeLeitura=2'b01, controleSalvaInstrucao=2'b00; go IDLE.
REQ-022 Exactly one controleSalvaInstrucao=2'b01 cycle per word; never asserted together with ControleFimDeLeitura=2'b01.
REQ-023 Latency: start sampled cycle 0 -> first ENVIA cycle 3 -> FIM at cycle 3N+1 (N=0: FIM at cycle 1).
REQ-024 iniciarLeitura outside IDLE ignored; captured address/length unchanged.
REQ-025 hdEndereco arithmetic 32-bit modulo 2^32 (wraps past 32'hFFFFFFFF).
REQ-026 Length > MEM_PROF: truncate to MEM_PROF words, erroTamanho=1 from cycle 1 until next start.
REQ-027 saidaDeInstrucao retains last word after transfer; palavrasEnviadas retains final count in IDLE.

Reset
REQ-028 reset=1 at any posedge: state IDLE; hdEndereco, saidaDeInstrucao, palavrasEnviadas = 0; hdLeitura, ocupado, erroTamanho = 0; both control outputs = 2'b00.
REQ-029 Reset mid-transfer aborts without FIM pulse; no further store pulses until a new start.
REQ-030 reset has priority over iniciarLeitura in the same cycle.

Structure
REQ-031 Shared package holds the state enumeration and constants CTRL_ATIVO=2'b01, CTRL_INATIVO=2'b00, shared with the instruction memory.
REQ-032 Single flat module; no sub-module (FSM plus one 32-bit counter and one adder).

Verification
REQ-033 Start, base 32'd10, length 3, HD[10..12]=A,B,C -> store pulses cycles 3,6,9 carrying A,B,C; FIM cycle 10; palavrasEnviadas=3.
REQ-034 Length 0 -> no hdLeitura, no store pulse, FIM at cycle 1, ocupado high cycles 1 only.
REQ-035 Length 300 -> exactly 201 store pulses, erroTamanho=1, final palavrasEnviadas=201.
REQ-036 Base 32'hFFFFFFFF, length 2 -> hdEndereco FFFFFFFF then 00000000.
REQ-037 reset asserted at second ENVIA of 5-word transfer -> all outputs zero next cycle, no FIM, IDLE.
REQ-038 iniciarLeitura pulsed mid-transfer with new base/length -> ignored; original transfer completes unchanged.

Source files
------------

// File: rtl/hd_program_loader_pkg.sv
// Shared types and constants for the HD program loader and instruction memory.
// Control codes are shared with the instruction-memory side.
package hd_program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LER,
    ESPERA,
    ENVIA,
    FIM
  } state_t;

  localparam logic [1:0] CTRL_ATIVO   = 2'b01;
  localparam logic [1:0] CTRL_INATIVO = 2'b00;

  localparam int unsigned MEM_PROF_DEF = 201;

endpackage

// File: rtl/hd_program_loader_if.sv
// Bus bundle between the loader, the HD reader and the instruction memory.
// The master side drives the start request and the HD read data.
interface hd_program_loader_if;

  logic        iniciarLeitura;
  logic [31:0] enderecoHD;
  logic [31:0] tamanhoPrograma;
  logic [31:0] hdEndereco;
  logic        hdLeitura;
  logic [31:0] hdDado;
  logic [31:0] saidaDeInstrucao;
  logic [1:0]  controleSalvaInstrucao;
  logic [1:0]  ControleFimDeLeitura;
  logic        ocupado;
  logic [31:0] palavrasEnviadas;
  logic        erroTamanho;

  modport master (
    output iniciarLeitura,
    output enderecoHD,
    output tamanhoPrograma,
    output hdDado,
    input  hdEndereco,
    input  hdLeitura,
    input  saidaDeInstrucao,
    input  controleSalvaInstrucao,
    input  ControleFimDeLeitura,
    input  ocupado,
    input  palavrasEnviadas,
    input  erroTamanho
  );

  modport slave (
    input  iniciarLeitura,
    input  enderecoHD,
    input  tamanhoPrograma,
    input  hdDado,
    output hdEndereco,
    output hdLeitura,
    output saidaDeInstrucao,
    output controleSalvaInstrucao,
    output ControleFimDeLeitura,
    output ocupado,
    output palavrasEnviadas,
    output erroTamanho
  );

endinterface

// File: rtl/hd_program_loader.sv
// Copies a program from the HD into instruction memory, one word per
// LER/ESPERA/ENVIA round; all outputs come straight from flops.
module hd_program_loader
  import hd_program_loader_pkg::*;
#(
  parameter int unsigned MEM_PROF = MEM_PROF_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  hd_program_loader_if.slave   bus
);

  localparam logic [31:0] MAXW = 32'(MEM_PROF);

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  salva_q, salva_d;
  logic [1:0]  fim_q, fim_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] len_in;

  assign len_in = (bus.tamanhoPrograma > MAXW) ? MAXW
                                               : bus.tamanhoPrograma;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    instr_d = instr_q;
    salva_d = CTRL_INATIVO;
    fim_d   = CTRL_INATIVO;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.iniciarLeitura) begin
          base_d = bus.enderecoHD;
          len_d  = len_in;
          cnt_d  = '0;
          err_d  = bus.tamanhoPrograma > MAXW;
          if (len_in == '0) begin
            state_d = FIM;
            fim_d   = CTRL_ATIVO;
          end else begin
            state_d = LER;
            rd_d    = 1'b1;
            addr_d  = bus.enderecoHD;
          end
        end
      end
      LER: begin
        state_d = ESPERA;
      end
      ESPERA: begin
        instr_d = bus.hdDado;
        salva_d = CTRL_ATIVO;
        state_d = ENVIA;
      end
      ENVIA: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_d < len_q) begin
          state_d = LER;
          rd_d    = 1'b1;
          // wraps modulo 2^32 by width
          addr_d  = base_q + cnt_d;
        end else begin
          state_d = FIM;
          fim_d   = CTRL_ATIVO;
        end
      end
      FIM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      instr_q <= '0;
      salva_q <= CTRL_INATIVO;
      fim_q   <= CTRL_INATIVO;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      instr_q <= instr_d;
      salva_q <= salva_d;
      fim_q   <= fim_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.hdEndereco             = addr_q;
  assign bus.hdLeitura              = rd_q;
  assign bus.saidaDeInstrucao       = instr_q;
  assign bus.controleSalvaInstrucao = salva_q;
  assign bus.ControleFimDeLeitura   = fim_q;
  assign bus.ocupado                = busy_q;
  assign bus.palavrasEnviadas       = cnt_q;
  assign bus.erroTamanho            = err_q;

endmodule

// File: tb/tb_hd_program_loader.sv
// Scoreboard bench for hd_program_loader: expected reads, stores and
// end-of-transfer pulses are queued at issue time and checked by a monitor.
module tb_hd_program_loader;
  import hd_program_loader_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   rd_cnt;

  ev_t         q_st[$];
  ev_t         q_fim[$];
  logic [31:0] q_adr[$];

  hd_program_loader_if bus();

  hd_program_loader #(.MEM_PROF(201)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] hd_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // HD model: data appears the cycle after the read strobe
  always @(posedge clk)
    if (bus.hdLeitura) bus.hdDado <= hd_word(bus.hdEndereco);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (bus.hdLeitura) begin
      rd_cnt++;
      if (q_adr.size() == 0) chk("adr_extra", bus.hdEndereco, 32'hx);
      else chk("hd_addr", bus.hdEndereco, q_adr.pop_front());
    end
    if (bus.controleSalvaInstrucao == CTRL_ATIVO) begin
      chk("store_vs_fim", 32'(bus.ControleFimDeLeitura), 32'(CTRL_INATIVO));
      if (q_st.size() == 0) chk("store_extra", 32'(cyc), 32'hx);
      else begin
        e = q_st.pop_front();
        chk("store_cyc", 32'(cyc), 32'(e.cyc));
        chk("store_data", bus.saidaDeInstrucao, e.val);
      end
    end
    if (bus.ControleFimDeLeitura == CTRL_ATIVO) begin
      if (q_fim.size() == 0) chk("fim_extra", 32'(cyc), 32'hx);
      else begin
        e = q_fim.pop_front();
        chk("fim_cyc", 32'(cyc), 32'(e.cyc));
        chk("fim_count", bus.palavrasEnviadas, e.val);
      end
    end
  end

  task automatic issue(input logic [31:0] base, input logic [31:0] len,
                       input int nw, input bit fim, output int p0);
    ev_t e;
    @(posedge clk);
    #1;
    bus.iniciarLeitura  = 1'b1;
    bus.enderecoHD      = base;
    bus.tamanhoPrograma = len;
    p0 = cyc;
    for (int i = 0; i < nw; i++) begin
      q_adr.push_back(base + 32'(i));
      e.cyc = p0 + 3 + 3 * i;
      e.val = hd_word(base + 32'(i));
      q_st.push_back(e);
    end
    if (fim) begin
      e.cyc = p0 + 3 * nw + 1;
      e.val = 32'(nw);
      q_fim.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.iniciarLeitura = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ocupado && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(bus.ocupado), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, bus.hdEndereco, 32'd0);
    chk({tag, "_rd"}, 32'(bus.hdLeitura), 32'd0);
    chk({tag, "_instr"}, bus.saidaDeInstrucao, 32'd0);
    chk({tag, "_salva"}, 32'(bus.controleSalvaInstrucao), 32'd0);
    chk({tag, "_fim"}, 32'(bus.ControleFimDeLeitura), 32'd0);
    chk({tag, "_busy"}, 32'(bus.ocupado), 32'd0);
    chk({tag, "_cnt"}, bus.palavrasEnviadas, 32'd0);
    chk({tag, "_err"}, 32'(bus.erroTamanho), 32'd0);
  endtask

  initial begin
    int p0;
    int rd0;
    total = 0;
    bad = 0;
    rd_cnt = 0;
    rst = 1'b1;
    bus.iniciarLeitura  = 1'b0;
    bus.enderecoHD      = '0;
    bus.tamanhoPrograma = '0;
    bus.hdDado          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    // start together with reset must be ignored
    #1 bus.iniciarLeitura = 1'b1;
    bus.tamanhoPrograma = 32'd4;
    @(posedge clk);
    #1 bus.iniciarLeitura = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", 32'(bus.ocupado), 32'd0);
    #1 rst = 1'b0;

    // three-word transfer from base 10
    issue(32'd10, 32'd3, 3, 1'b1, p0);
    wait_idle(50);
    chk("t1_count", bus.palavrasEnviadas, 32'd3);
    chk("t1_retain", bus.saidaDeInstrucao, 32'h5A5A_000C);

    // zero-length transfer
    rd0 = rd_cnt;
    issue(32'd77, 32'd0, 0, 1'b1, p0);
    @(negedge clk);
    chk("t2_busy_c1", 32'(bus.ocupado), 32'd1);
    @(negedge clk);
    chk("t2_busy_c2", 32'(bus.ocupado), 32'd0);
    chk("t2_no_read", 32'(rd_cnt - rd0), 32'd0);
    chk("t2_count", bus.palavrasEnviadas, 32'd0);

    // oversize transfer truncates to 201 words
    issue(32'd1000, 32'd300, 201, 1'b1, p0);
    @(negedge clk);
    chk("t3_err_c1", 32'(bus.erroTamanho), 32'd1);
    wait_idle(1000);
    chk("t3_count", bus.palavrasEnviadas, 32'd201);
    chk("t3_err", 32'(bus.erroTamanho), 32'd1);

    // address wrap past all-ones
    issue(32'hFFFF_FFFF, 32'd2, 2, 1'b1, p0);
    @(negedge clk);
    chk("t4_err_clr", 32'(bus.erroTamanho), 32'd0);
    wait_idle(50);
    chk("t4_retain", bus.saidaDeInstrucao, 32'h5A5A_0000);

    // reset at the second store of a five-word transfer
    issue(32'd20, 32'd5, 2, 1'b0, p0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("t5");
    repeat (12) @(negedge clk);
    chk("t5_idle", 32'(bus.ocupado), 32'd0);

    // restart request mid-transfer is ignored
    issue(32'd40, 32'd2, 2, 1'b1, p0);
    repeat (3) @(posedge clk);
    #1;
    bus.iniciarLeitura  = 1'b1;
    bus.enderecoHD      = 32'd99;
    bus.tamanhoPrograma = 32'd7;
    @(posedge clk);
    #1 bus.iniciarLeitura = 1'b0;
    wait_idle(50);
    chk("t6_count", bus.palavrasEnviadas, 32'd2);
    repeat (4) @(negedge clk);
    chk("t6_idle", 32'(bus.ocupado), 32'd0);

    chk("q_adr_empty", 32'(q_adr.size()), 32'd0);
    chk("q_st_empty", 32'(q_st.size()), 32'd0);
    chk("q_fim_empty", 32'(q_fim.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
